// File: rtl/sid_dac_serializer.sv
// Serializes two 12-bit SID channel samples MSB-first to a pair of serial DACs sharing clk/csb/leb.
// Optional SID_DAC_OVERRUN_EN adds an 8-bit saturating count of overwritten pending pairs.
module sid_dac_serializer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_1,
    input  logic [11:0] sample_2,
    input  logic        sample_valid,
    input  logic        dac_buffered,
    output logic        DAC_clk,
    output logic        DAC_dat_1,
    output logic        DAC_dat_2,
    output logic        DAC_csb,
    output logic        DAC_leb,
    output logic        busy
`ifdef SID_DAC_OVERRUN_EN
    ,
    output logic [7:0]  overrun_cnt
`endif
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_LATCH,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic               phase_q, phase_d;
    logic [15:0]        sr1_q, sr1_d, sr2_q, sr2_d;
    logic               pv_q, pv_d;
    logic [11:0]        p1_q, p1_d, p2_q, p2_d;
    logic               dclk_q, dclk_d;
    logic               dat1_q, dat1_d, dat2_q, dat2_d;
    logic               csb_q, csb_d, leb_q, leb_d, busy_q, busy_d;
    logic               load_new, load_pend, div_done, in_frame;
`ifdef SID_DAC_OVERRUN_EN
    logic [7:0]         ovr_q, ovr_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        pv_d      = pv_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        load_new  = 1'b0;
        load_pend = 1'b0;
        div_done  = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    load_new = 1'b1;
                end else if (pv_q) begin
                    load_pend = 1'b1;
                end
            end
            S_SETUP: begin
                if (div_done) begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_SHIFT: begin
                if (div_done) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // Bit boundary is the high->low transition; data moves only then.
                    if (phase_q) begin
                        if (bit_q == 4'd15) begin
                            bit_d   = 4'd0;
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + 4'd1;
                            sr1_d = {sr1_q[14:0], 1'b0};
                            sr2_d = {sr2_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HOLD, S_LATCH: begin
                if (div_done) begin
                    div_d   = '0;
                    state_d = (state_q == S_HOLD) ? S_LATCH : S_GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (div_done) begin
                    div_d = '0;
                    if (pv_q) begin
                        load_pend = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_new || load_pend) begin
            sr1_d   = {1'b0, dac_buffered, 2'b11, (load_pend ? p1_q : sample_1)};
            sr2_d   = {1'b0, dac_buffered, 2'b11, (load_pend ? p2_q : sample_2)};
            state_d = S_SETUP;
            div_d   = '0;
            bit_d   = 4'd0;
            phase_d = 1'b0;
            pv_d    = 1'b0;
        end

        // A strobe while a frame is in flight lands in the one-deep slot (newest wins).
        if (sample_valid && (state_q != S_IDLE)) begin
            pv_d = 1'b1;
            p1_d = sample_1;
            p2_d = sample_2;
        end

        in_frame = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        dclk_d   = (state_d == S_SHIFT) && phase_d;
        dat1_d   = in_frame ? sr1_d[15] : 1'b0;
        dat2_d   = in_frame ? sr2_d[15] : 1'b0;
        csb_d    = ~in_frame;
        leb_d    = (state_d != S_LATCH);
        busy_d   = (state_d != S_IDLE);

`ifdef SID_DAC_OVERRUN_EN
        ovr_d = ovr_q;
        if (sample_valid && pv_q && !load_pend && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
            sr1_q   <= 16'd0;
            sr2_q   <= 16'd0;
            pv_q    <= 1'b0;
            p1_q    <= 12'd0;
            p2_q    <= 12'd0;
            dclk_q  <= 1'b0;
            dat1_q  <= 1'b0;
            dat2_q  <= 1'b0;
            csb_q   <= 1'b1;
            leb_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SID_DAC_OVERRUN_EN
            ovr_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            pv_q    <= pv_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dclk_q  <= dclk_d;
            dat1_q  <= dat1_d;
            dat2_q  <= dat2_d;
            csb_q   <= csb_d;
            leb_q   <= leb_d;
            busy_q  <= busy_d;
`ifdef SID_DAC_OVERRUN_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign DAC_clk   = dclk_q;
    assign DAC_dat_1 = dat1_q;
    assign DAC_dat_2 = dat2_q;
    assign DAC_csb   = csb_q;
    assign DAC_leb   = leb_q;
    assign busy      = busy_q;
`ifdef SID_DAC_OVERRUN_EN
    assign overrun_cnt = ovr_q;
`endif

endmodule

// File: doc/sid_dac_serializer.md
Name: sid_dac_serializer

Overview:
Output stage downstream of the SID voice/filter mixer. Takes two parallel 12-bit channel samples and shifts them MSB-first to two external serial DACs. The DACs share clock, chip-select and latch-enable, with one data line each. Generates DAC_clk/DAC_dat_1/DAC_dat_2/DAC_csb/DAC_leb framing and holds one new sample pair while a frame is in flight.

Parameters:
CLK_DIV, 2, system clocks per DAC_clk half-period (D); legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sample_1  input  12  channel-1 sample, sent raw (no inversion)
sample_2  input  12  channel-2 sample, sent raw
sample_valid  input  1  single-cycle strobe; sample pair valid this cycle
dac_buffered  input  1  DAC BUF configuration bit, captured at frame load
DAC_clk  output  1  serial clock; idles low
DAC_dat_1  output  1  serial data, channel 1
DAC_dat_2  output  1  serial data, channel 2
DAC_csb  output  1  chip select, active low
DAC_leb  output  1  latch enable (LDAC), active low
busy  output  1  high from frame load until the end of the GAP state

Behaviour:
- Reset (async, immediate): DAC_clk=0, DAC_dat_1/2=0, DAC_csb=1, DAC_leb=1, busy=0, pending slot cleared, FSM=IDLE, counters zeroed.
- Frame word per channel: {1'b0 (A/B), BUF, 1'b1 (GAb), 1'b1 (SHDNb), sample[11:0]}. BUF is dac_buffered captured at load.
- FSM states, with D = CLK_DIV:
  - IDLE: csb=1, leb=1, clk=0. On sample_valid, load both shift registers at that edge, set busy, go to SETUP.
  - SETUP, D cycles: csb=0, clk=0, data = bit15.
  - SHIFT, 16 bits: for each bit, clk low D cycles, then high D cycles. Data advances to the next bit on the cycle clk returns low, never while clk is high. After bit0's high phase, go to HOLD.
  - HOLD, D cycles: clk=0, csb=0. Then csb=1.
  - LATCH, D cycles: csb=1, leb=0.
  - GAP, D cycles: csb=1, leb=1.
- End of GAP: if the pending slot is valid, load it and go directly to SETUP (busy stays high); otherwise go to IDLE and drop busy.
- Frame length: 36*D cycles from load edge to IDLE. At D=2 this is 72 cycles; back-to-back frame period is also 72.
- Latency: the first DAC_csb fall is registered, one cycle after the sample_valid cycle.
- Pending slot, one deep:
  - sample_valid outside IDLE writes the slot (both samples) and sets its valid bit.
  - A newer strobe overwrites an older pending pair.
  - If sample_valid coincides with the GAP-end pending load, the loaded pair goes out and the new pair becomes pending.
- dac_buffered is not captured for pending pairs; it is read at the actual frame load.
- DAC_clk/DAC_dat/DAC_csb/DAC_leb are driven from flops; no combinational path from inputs to pins.
- Divider counter width: $clog2(CLK_DIV+1). Bit counter: 4 bits, wraps 15→0 only at SHIFT exit.

Optional Feature:
SID_DAC_OVERRUN_EN:
- Defined: adds output port overrun_cnt (8 bits, reset 0). It increments by one each cycle sample_valid overwrites a still-valid pending pair, and saturates at 8'hFF.
- Undefined: port and logic absent. Overwrite behaviour is identical but uncounted.

Test Plan:
- Reset mid-SHIFT (bit 7) -> same cycle: csb=1, leb=1, clk=0, dat=0, busy=0. After release, one strobe yields a clean full frame.
- D=2, dac_buffered=1, sample_1=12'hA5C, sample_2=12'h3F0, one strobe -> DAC_dat_1 sampled on DAC_clk rises = 16'h7A5C and DAC_dat_2 = 16'h73F0 (MSB first). DAC_leb low 2 cycles after csb rises. busy high exactly 72 cycles.
- dac_buffered=0, both samples 12'h000 -> words 16'h3000/16'h3000. Exactly 16 DAC_clk rising edges per csb-low window.
- Strobe A in IDLE, strobe B at cycle 10 -> frame A, then frame B starting with no IDLE gap. busy stays high 144 cycles; DAC_csb high exactly 2*D cycles (LATCH+GAP) between frames.
- Strobes A (IDLE), B at cycle 10, C at cycle 20 -> frames A then C only. With SID_DAC_OVERRUN_EN, overrun_cnt=1.
- CLK_DIV=1 -> frame period 36 cycles. DAC_clk toggles every cycle in SHIFT. Data never changes while DAC_clk is high.
